// File: rtl/id_ex_stage_if.sv
// Decode-to-execute issue bus: decode offer, register file reads, bypass sources,
// flush, and the registered execute-side outputs of id_ex_stage.
interface id_ex_stage_if #(
    parameter int unsigned XLEN = 64
);
    logic            dec_valid_i;
    logic            dec_ready_o;
    logic [XLEN-1:0] dec_pc_i;
    logic [XLEN-1:0] dec_imm_i;
    logic [4:0]      dec_rs1_addr_i;
    logic [4:0]      dec_rs2_addr_i;
    logic [4:0]      dec_rd_addr_i;
    logic            dec_rd_wen_i;
    logic            dec_is_load_i;
    logic            dec_is_store_i;
    logic [1:0]      dec_opa_sel_i;
    logic            dec_opb_sel_i;
    logic [3:0]      dec_alu_func_i;

    logic [XLEN-1:0] rf_rs1_data_i;
    logic [XLEN-1:0] rf_rs2_data_i;
    logic [XLEN-1:0] alu_res_i;

    logic            exm_valid_i;
    logic            exm_rd_wen_i;
    logic            exm_is_load_i;
    logic [4:0]      exm_rd_addr_i;
    logic [XLEN-1:0] exm_rd_data_i;

    logic            wb_valid_i;
    logic            wb_rd_wen_i;
    logic [4:0]      wb_rd_addr_i;
    logic [XLEN-1:0] wb_rd_data_i;

    logic            flush_i;

    logic            ex_valid_o;
    logic            ex_ready_i;
    logic [XLEN-1:0] opr_a_o;
    logic [XLEN-1:0] opr_b_o;
    logic [3:0]      alu_func_o;
    logic [XLEN-1:0] ex_rs2_data_o;
    logic [XLEN-1:0] ex_pc_o;
    logic [4:0]      ex_rd_addr_o;
    logic            ex_rd_wen_o;
    logic            ex_is_load_o;
    logic            ex_is_store_o;

    // Pipeline environment (decode, RF, downstream stages)
    modport master (
        output dec_valid_i, dec_pc_i, dec_imm_i, dec_rs1_addr_i, dec_rs2_addr_i,
               dec_rd_addr_i, dec_rd_wen_i, dec_is_load_i, dec_is_store_i,
               dec_opa_sel_i, dec_opb_sel_i, dec_alu_func_i,
               rf_rs1_data_i, rf_rs2_data_i, alu_res_i,
               exm_valid_i, exm_rd_wen_i, exm_is_load_i, exm_rd_addr_i, exm_rd_data_i,
               wb_valid_i, wb_rd_wen_i, wb_rd_addr_i, wb_rd_data_i,
               flush_i, ex_ready_i,
        input  dec_ready_o, ex_valid_o, opr_a_o, opr_b_o, alu_func_o, ex_rs2_data_o,
               ex_pc_o, ex_rd_addr_o, ex_rd_wen_o, ex_is_load_o, ex_is_store_o
    );

    // The issue stage itself
    modport slave (
        input  dec_valid_i, dec_pc_i, dec_imm_i, dec_rs1_addr_i, dec_rs2_addr_i,
               dec_rd_addr_i, dec_rd_wen_i, dec_is_load_i, dec_is_store_i,
               dec_opa_sel_i, dec_opb_sel_i, dec_alu_func_i,
               rf_rs1_data_i, rf_rs2_data_i, alu_res_i,
               exm_valid_i, exm_rd_wen_i, exm_is_load_i, exm_rd_addr_i, exm_rd_data_i,
               wb_valid_i, wb_rd_wen_i, wb_rd_addr_i, wb_rd_data_i,
               flush_i, ex_ready_i,
        output dec_ready_o, ex_valid_o, opr_a_o, opr_b_o, alu_func_o, ex_rs2_data_o,
               ex_pc_o, ex_rd_addr_o, ex_rd_wen_o, ex_is_load_o, ex_is_store_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX issue register: operand selection with three-level bypass, load-use stall,
// single-entry valid/ready hold with flush and synchronous reset.
module id_ex_stage #(
    parameter int unsigned XLEN = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);
    logic            ex_fire;
    logic            held_fwd;
    logic            exm_fwd;
    logic            wb_fwd;
    logic            held_ld;
    logic            exm_ld;
    logic            rs1_used;
    logic            rs2_used;
    logic            rs1_hazard;
    logic            rs2_hazard;
    logic            stall;
    logic            ready;
    logic            capture;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] opa_val;
    logic [XLEN-1:0] opb_val;

    // Bypass selection, hazard detection and handshake
    always_comb begin
        ex_fire  = bus.ex_valid_o & bus.ex_ready_i;
        held_fwd = ex_fire & bus.ex_rd_wen_o & ~bus.ex_is_load_o;
        exm_fwd  = bus.exm_valid_i & bus.exm_rd_wen_i & ~bus.exm_is_load_i;
        wb_fwd   = bus.wb_valid_i & bus.wb_rd_wen_i;
        held_ld  = bus.ex_valid_o & bus.ex_is_load_o & bus.ex_rd_wen_o;
        exm_ld   = bus.exm_valid_i & bus.exm_is_load_i & bus.exm_rd_wen_i;
        rs1_used = (bus.dec_opa_sel_i == 2'd0);
        rs2_used = ~bus.dec_opb_sel_i | bus.dec_is_store_i;

        rs1_fwd = bus.rf_rs1_data_i;
        if (bus.dec_rs1_addr_i != 5'd0) begin
            if (held_fwd && bus.ex_rd_addr_o == bus.dec_rs1_addr_i)
                rs1_fwd = bus.alu_res_i;
            else if (exm_fwd && bus.exm_rd_addr_i == bus.dec_rs1_addr_i)
                rs1_fwd = bus.exm_rd_data_i;
            else if (wb_fwd && bus.wb_rd_addr_i == bus.dec_rs1_addr_i)
                rs1_fwd = bus.wb_rd_data_i;
        end

        rs2_fwd = bus.rf_rs2_data_i;
        if (bus.dec_rs2_addr_i != 5'd0) begin
            if (held_fwd && bus.ex_rd_addr_o == bus.dec_rs2_addr_i)
                rs2_fwd = bus.alu_res_i;
            else if (exm_fwd && bus.exm_rd_addr_i == bus.dec_rs2_addr_i)
                rs2_fwd = bus.exm_rd_data_i;
            else if (wb_fwd && bus.wb_rd_addr_i == bus.dec_rs2_addr_i)
                rs2_fwd = bus.wb_rd_data_i;
        end

        rs1_hazard = rs1_used && (bus.dec_rs1_addr_i != 5'd0) &&
                     ((held_ld && bus.ex_rd_addr_o == bus.dec_rs1_addr_i) ||
                      (exm_ld && bus.exm_rd_addr_i == bus.dec_rs1_addr_i));
        rs2_hazard = rs2_used && (bus.dec_rs2_addr_i != 5'd0) &&
                     ((held_ld && bus.ex_rd_addr_o == bus.dec_rs2_addr_i) ||
                      (exm_ld && bus.exm_rd_addr_i == bus.dec_rs2_addr_i));
        stall   = rs1_hazard | rs2_hazard;
        ready   = (~bus.ex_valid_o | bus.ex_ready_i) & ~stall & ~bus.flush_i;
        capture = bus.dec_valid_i & ready;

        case (bus.dec_opa_sel_i)
            2'd0:    opa_val = rs1_fwd;
            2'd1:    opa_val = bus.dec_pc_i;
            default: opa_val = '0;
        endcase
        opb_val = bus.dec_opb_sel_i ? bus.dec_imm_i : rs2_fwd;
    end

    assign bus.dec_ready_o = ready;

    // Issue register: reset > flush > capture > drain > hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.ex_valid_o    <= 1'b0;
            bus.opr_a_o       <= '0;
            bus.opr_b_o       <= '0;
            bus.alu_func_o    <= '0;
            bus.ex_rs2_data_o <= '0;
            bus.ex_pc_o       <= '0;
            bus.ex_rd_addr_o  <= '0;
            bus.ex_rd_wen_o   <= 1'b0;
            bus.ex_is_load_o  <= 1'b0;
            bus.ex_is_store_o <= 1'b0;
        end else if (bus.flush_i) begin
            bus.ex_valid_o <= 1'b0;
        end else if (capture) begin
            bus.ex_valid_o    <= 1'b1;
            bus.opr_a_o       <= opa_val;
            bus.opr_b_o       <= opb_val;
            bus.alu_func_o    <= bus.dec_alu_func_i;
            bus.ex_rs2_data_o <= rs2_fwd;
            bus.ex_pc_o       <= bus.dec_pc_i;
            bus.ex_rd_addr_o  <= bus.dec_rd_addr_i;
            bus.ex_rd_wen_o   <= bus.dec_rd_wen_i;
            bus.ex_is_load_o  <= bus.dec_is_load_i;
            bus.ex_is_store_o <= bus.dec_is_store_i;
        end else if (ex_fire) begin
            bus.ex_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the issue register.
module tb_id_ex_stage;
    localparam int unsigned XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN)) bus ();
    id_ex_stage #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

    typedef struct {
        bit          valid;
        logic [4:0]  rd;
        bit          wen;
        bit          ld;
        bit          st;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  func;
        logic [63:0] rs2d;
        logic [63:0] pc;
    } ex_t;

    ex_t m;

    function automatic logic [269:0] dut_outs();
        return {bus.ex_valid_o, bus.ex_rd_addr_o, bus.ex_rd_wen_o, bus.ex_is_load_o,
                bus.ex_is_store_o, bus.opr_a_o, bus.opr_b_o, bus.alu_func_o,
                bus.ex_rs2_data_o, bus.ex_pc_o};
    endfunction

    function automatic logic [269:0] model_outs(input ex_t e);
        return {e.valid, e.rd, e.wen, e.ld, e.st, e.a, e.b, e.func, e.rs2d, e.pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dec_valid_i = 0; bus.dec_pc_i = '0; bus.dec_imm_i = '0;
        bus.dec_rs1_addr_i = '0; bus.dec_rs2_addr_i = '0; bus.dec_rd_addr_i = '0;
        bus.dec_rd_wen_i = 0; bus.dec_is_load_i = 0; bus.dec_is_store_i = 0;
        bus.dec_opa_sel_i = 2'd0; bus.dec_opb_sel_i = 1'b1; bus.dec_alu_func_i = '0;
        bus.rf_rs1_data_i = '0; bus.rf_rs2_data_i = '0; bus.alu_res_i = '0;
        bus.exm_valid_i = 0; bus.exm_rd_wen_i = 0; bus.exm_is_load_i = 0;
        bus.exm_rd_addr_i = '0; bus.exm_rd_data_i = '0;
        bus.wb_valid_i = 0; bus.wb_rd_wen_i = 0; bus.wb_rd_addr_i = '0; bus.wb_rd_data_i = '0;
        bus.flush_i = 0; bus.ex_ready_i = 1;
    endtask

    task automatic set_instr(input logic [63:0] pc, input logic [63:0] imm,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input bit wen, input bit ld, input bit st,
                             input logic [1:0] opa, input bit opb, input logic [3:0] func);
        bus.dec_valid_i = 1; bus.dec_pc_i = pc; bus.dec_imm_i = imm;
        bus.dec_rs1_addr_i = rs1; bus.dec_rs2_addr_i = rs2; bus.dec_rd_addr_i = rd;
        bus.dec_rd_wen_i = wen; bus.dec_is_load_i = ld; bus.dec_is_store_i = st;
        bus.dec_opa_sel_i = opa; bus.dec_opb_sel_i = opb; bus.dec_alu_func_i = func;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); rst = 0;
        n_checks++;
        if (dut_outs() !== 270'd0) $display("FAIL reset_outs: got %h expected 0", dut_outs());
        else n_pass++;
        n_checks++;
        if (bus.dec_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.dec_ready_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        set_instr(64'h100, 64'd0, 5'd10, 5'd11, 5'd1, 1, 0, 0, 2'd0, 0, 4'd0);
        bus.rf_rs1_data_i = 64'd5; bus.rf_rs2_data_i = 64'd7;
        tick();
        n_checks++;
        if (bus.ex_valid_o !== 1'b1 || bus.opr_a_o !== 64'd5 || bus.opr_b_o !== 64'd7)
            $display("FAIL b2b_first: got v=%b a=%h b=%h expected v=1 a=5 b=7",
                     bus.ex_valid_o, bus.opr_a_o, bus.opr_b_o);
        else n_pass++;
        set_instr(64'h104, 64'd1, 5'd1, 5'd0, 5'd2, 1, 0, 0, 2'd0, 1, 4'd0);
        bus.rf_rs1_data_i = 64'd0; bus.rf_rs2_data_i = 64'd0; bus.alu_res_i = 64'd12;
        #1;
        n_checks++;
        if (bus.dec_ready_o !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", bus.dec_ready_o);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.opr_a_o !== 64'd12 || bus.opr_b_o !== 64'd1 || bus.ex_rd_addr_o !== 5'd2)
            $display("FAIL b2b_fwd: got a=%h b=%h rd=%0d expected a=c b=1 rd=2",
                     bus.opr_a_o, bus.opr_b_o, bus.ex_rd_addr_o);
        else n_pass++;
        idle_inputs(); tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        set_instr(64'h200, 64'd8, 5'd0, 5'd0, 5'd3, 1, 1, 0, 2'd0, 1, 4'd0);
        tick();
        set_instr(64'h204, 64'd0, 5'd3, 5'd0, 5'd4, 1, 0, 0, 2'd0, 0, 4'd0);
        #1;
        n_checks++;
        if (bus.dec_ready_o !== 1'b0) $display("FAIL lu_stall1: got %b expected 0", bus.dec_ready_o);
        else n_pass++;
        tick();
        bus.exm_valid_i = 1; bus.exm_is_load_i = 1; bus.exm_rd_wen_i = 1; bus.exm_rd_addr_i = 5'd3;
        #1;
        n_checks++;
        if (bus.dec_ready_o !== 1'b0) $display("FAIL lu_stall2: got %b expected 0", bus.dec_ready_o);
        else n_pass++;
        tick();
        bus.exm_valid_i = 0; bus.exm_is_load_i = 0; bus.exm_rd_wen_i = 0;
        bus.wb_valid_i = 1; bus.wb_rd_wen_i = 1; bus.wb_rd_addr_i = 5'd3; bus.wb_rd_data_i = 64'h55;
        #1;
        n_checks++;
        if (bus.dec_ready_o !== 1'b1) $display("FAIL lu_release: got %b expected 1", bus.dec_ready_o);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.opr_a_o !== 64'h55 || bus.opr_b_o !== 64'd0 || bus.ex_rd_addr_o !== 5'd4)
            $display("FAIL lu_opr: got a=%h b=%h rd=%0d expected a=55 b=0 rd=4",
                     bus.opr_a_o, bus.opr_b_o, bus.ex_rd_addr_o);
        else n_pass++;
        idle_inputs(); tick();
    endtask

    task automatic test_priority();
        idle_inputs();
        set_instr(64'h300, 64'd0, 5'd0, 5'd5, 5'd6, 1, 0, 0, 2'd0, 0, 4'd0);
        bus.rf_rs2_data_i = 64'h77;
        bus.exm_valid_i = 1; bus.exm_rd_wen_i = 1; bus.exm_rd_addr_i = 5'd5; bus.exm_rd_data_i = 64'd9;
        bus.wb_valid_i = 1; bus.wb_rd_wen_i = 1; bus.wb_rd_addr_i = 5'd5; bus.wb_rd_data_i = 64'd3;
        tick();
        n_checks++;
        if (bus.opr_b_o !== 64'd9 || bus.opr_a_o !== 64'd0)
            $display("FAIL prio_exm: got a=%h b=%h expected a=0 b=9", bus.opr_a_o, bus.opr_b_o);
        else n_pass++;
        bus.exm_valid_i = 0;
        tick();
        n_checks++;
        if (bus.opr_b_o !== 64'd3) $display("FAIL prio_wb: got b=%h expected 3", bus.opr_b_o);
        else n_pass++;
        bus.wb_rd_addr_i = 5'd0; bus.wb_rd_data_i = 64'hFF;
        bus.exm_valid_i = 1; bus.exm_rd_addr_i = 5'd0; bus.exm_rd_data_i = 64'hEE;
        bus.dec_opb_sel_i = 1; bus.dec_imm_i = 64'd2;
        tick();
        n_checks++;
        if (bus.opr_a_o !== 64'd0) $display("FAIL prio_x0: got a=%h expected 0", bus.opr_a_o);
        else n_pass++;
        idle_inputs(); tick();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        set_instr(64'h2000, 64'h33, 5'd0, 5'd0, 5'd7, 1, 0, 0, 2'd1, 1, 4'd5);
        tick();
        bus.ex_ready_i = 0;
        set_instr(64'h3000, 64'h44, 5'd0, 5'd0, 5'd8, 1, 0, 0, 2'd1, 1, 4'd6);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.dec_ready_o !== 1'b0) $display("FAIL bp_ready%0d: got %b expected 0", i, bus.dec_ready_o);
            else n_pass++;
            tick();
            n_checks++;
            if (bus.ex_valid_o !== 1'b1 || bus.opr_a_o !== 64'h2000 || bus.opr_b_o !== 64'h33 ||
                bus.alu_func_o !== 4'd5 || bus.ex_rd_addr_o !== 5'd7)
                $display("FAIL bp_hold%0d: got v=%b a=%h b=%h f=%h rd=%0d expected v=1 a=2000 b=33 f=5 rd=7",
                         i, bus.ex_valid_o, bus.opr_a_o, bus.opr_b_o, bus.alu_func_o, bus.ex_rd_addr_o);
            else n_pass++;
        end
        bus.ex_ready_i = 1;
        #1;
        n_checks++;
        if (bus.dec_ready_o !== 1'b1) $display("FAIL bp_release: got %b expected 1", bus.dec_ready_o);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.opr_a_o !== 64'h3000 || bus.alu_func_o !== 4'd6 || bus.ex_valid_o !== 1'b1)
            $display("FAIL bp_next: got a=%h f=%h v=%b expected a=3000 f=6 v=1",
                     bus.opr_a_o, bus.alu_func_o, bus.ex_valid_o);
        else n_pass++;
    endtask

    task automatic test_flush_reset();
        set_instr(64'h4000, 64'h1, 5'd0, 5'd0, 5'd9, 1, 0, 0, 2'd1, 1, 4'd2);
        bus.ex_ready_i = 0; bus.flush_i = 1;
        #1;
        n_checks++;
        if (bus.dec_ready_o !== 1'b0) $display("FAIL flush_ready: got %b expected 0", bus.dec_ready_o);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.ex_valid_o !== 1'b0) $display("FAIL flush_valid: got %b expected 0", bus.ex_valid_o);
        else n_pass++;
        bus.flush_i = 0; bus.ex_ready_i = 1;
        tick();
        n_checks++;
        if (bus.ex_valid_o !== 1'b1 || bus.ex_pc_o !== 64'h4000)
            $display("FAIL flush_recover: got v=%b pc=%h expected v=1 pc=4000", bus.ex_valid_o, bus.ex_pc_o);
        else n_pass++;
        set_instr(64'h5000, 64'h2, 5'd0, 5'd0, 5'd10, 1, 0, 1, 2'd1, 1, 4'd3);
        rst = 1;
        tick();
        rst = 0;
        n_checks++;
        if (dut_outs() !== 270'd0) $display("FAIL midreset_outs: got %h expected 0", dut_outs());
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_opsel();
        idle_inputs();
        set_instr(64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 5'd1, 1, 0, 0, 2'd1, 1, 4'd0);
        tick();
        n_checks++;
        if (bus.opr_a_o !== 64'h1000 || bus.opr_b_o !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL opsel_pc_imm: got a=%h b=%h expected a=1000 b=fffffffffffffffc",
                     bus.opr_a_o, bus.opr_b_o);
        else n_pass++;
        for (int s = 2; s < 4; s++) begin
            set_instr(64'h1100, 64'h9, 5'd4, 5'd0, 5'd1, 1, 0, 0, 2'(s), 1, 4'd0);
            bus.rf_rs1_data_i = 64'h99;
            tick();
            n_checks++;
            if (bus.opr_a_o !== 64'd0) $display("FAIL opsel_zero%0d: got a=%h expected 0", s, bus.opr_a_o);
            else n_pass++;
        end
        idle_inputs(); tick();
    endtask

    // Model: first matching bypass source in pipeline order, else register file
    function automatic logic [63:0] model_src(input logic [4:0] rs, input logic [63:0] rfd, input bit fire);
        bit          hit [3];
        logic [63:0] val [3];
        hit[0] = fire && m.wen && !m.ld && m.rd == rs;                         val[0] = bus.alu_res_i;
        hit[1] = bus.exm_valid_i && bus.exm_rd_wen_i && !bus.exm_is_load_i &&
                 bus.exm_rd_addr_i == rs;                                      val[1] = bus.exm_rd_data_i;
        hit[2] = bus.wb_valid_i && bus.wb_rd_wen_i && bus.wb_rd_addr_i == rs;  val[2] = bus.wb_rd_data_i;
        if (rs == 5'd0) return rfd;
        for (int k = 0; k < 3; k++) if (hit[k]) return val[k];
        return rfd;
    endfunction

    function automatic bit model_load_dep(input logic [4:0] rs);
        if (rs == 5'd0) return 0;
        if (m.valid && m.ld && m.wen && m.rd == rs) return 1;
        if (bus.exm_valid_i && bus.exm_is_load_i && bus.exm_rd_wen_i && bus.exm_rd_addr_i == rs) return 1;
        return 0;
    endfunction

    task automatic test_random();
        ex_t nx;
        bit  fire, stall, exp_ready;
        idle_inputs();
        rst = 1; tick(); rst = 0;
        m = '{default: '0};
        for (int c = 0; c < 400; c++) begin
            bus.dec_valid_i    = ($urandom_range(0, 4) != 0);
            bus.dec_pc_i       = {$urandom, $urandom};
            bus.dec_imm_i      = {$urandom, $urandom};
            bus.dec_rs1_addr_i = 5'($urandom_range(0, 3));
            bus.dec_rs2_addr_i = 5'($urandom_range(0, 3));
            bus.dec_rd_addr_i  = 5'($urandom_range(0, 3));
            bus.dec_rd_wen_i   = 1'($urandom);
            bus.dec_is_load_i  = ($urandom_range(0, 2) == 0);
            bus.dec_is_store_i = ($urandom_range(0, 3) == 0);
            bus.dec_opa_sel_i  = 2'($urandom);
            bus.dec_opb_sel_i  = 1'($urandom);
            bus.dec_alu_func_i = 4'($urandom);
            bus.rf_rs1_data_i  = (bus.dec_rs1_addr_i == 0) ? 64'd0 : {$urandom, $urandom};
            bus.rf_rs2_data_i  = (bus.dec_rs2_addr_i == 0) ? 64'd0 : {$urandom, $urandom};
            bus.alu_res_i      = {$urandom, $urandom};
            bus.exm_valid_i    = 1'($urandom);
            bus.exm_rd_wen_i   = ($urandom_range(0, 3) != 0);
            bus.exm_is_load_i  = ($urandom_range(0, 2) == 0);
            bus.exm_rd_addr_i  = 5'($urandom_range(0, 3));
            bus.exm_rd_data_i  = {$urandom, $urandom};
            bus.wb_valid_i     = 1'($urandom);
            bus.wb_rd_wen_i    = ($urandom_range(0, 3) != 0);
            bus.wb_rd_addr_i   = 5'($urandom_range(0, 3));
            bus.wb_rd_data_i   = {$urandom, $urandom};
            bus.flush_i        = ($urandom_range(0, 11) == 0);
            bus.ex_ready_i     = ($urandom_range(0, 3) != 0);
            rst                = ($urandom_range(0, 59) == 0);
            #1;
            fire  = m.valid && bus.ex_ready_i;
            stall = ((bus.dec_opa_sel_i == 0) && model_load_dep(bus.dec_rs1_addr_i)) ||
                    ((!bus.dec_opb_sel_i || bus.dec_is_store_i) && model_load_dep(bus.dec_rs2_addr_i));
            exp_ready = (!m.valid || bus.ex_ready_i) && !stall && !bus.flush_i;
            n_checks++;
            if (bus.dec_ready_o !== exp_ready)
                $display("FAIL rand_ready[%0d]: got %b expected %b", c, bus.dec_ready_o, exp_ready);
            else n_pass++;
            nx = m;
            if (rst) begin
                nx = '{default: '0};
            end else if (bus.flush_i) begin
                nx.valid = 0;
            end else if (bus.dec_valid_i && exp_ready) begin
                nx.valid = 1;
                nx.rd    = bus.dec_rd_addr_i;
                nx.wen   = bus.dec_rd_wen_i;
                nx.ld    = bus.dec_is_load_i;
                nx.st    = bus.dec_is_store_i;
                nx.func  = bus.dec_alu_func_i;
                nx.pc    = bus.dec_pc_i;
                nx.rs2d  = model_src(bus.dec_rs2_addr_i, bus.rf_rs2_data_i, fire);
                nx.a     = (bus.dec_opa_sel_i == 0) ? model_src(bus.dec_rs1_addr_i, bus.rf_rs1_data_i, fire) :
                           (bus.dec_opa_sel_i == 1) ? bus.dec_pc_i : 64'd0;
                nx.b     = bus.dec_opb_sel_i ? bus.dec_imm_i : nx.rs2d;
            end else if (fire) begin
                nx.valid = 0;
            end
            m = nx;
            tick();
            rst = 0;
            n_checks++;
            if (dut_outs() !== model_outs(m))
                $display("FAIL rand_outs[%0d]: got %h expected %h", c, dut_outs(), model_outs(m));
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_priority();
        test_backpressure();
        test_flush_reset();
        test_opsel();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Issue register between decode and the execute ALU. Accepts one decoded instruction per cycle over a valid/ready handshake, selects and forwards operands (register file, PC, immediate, in-flight results), detects load-use hazards, and holds registered `opr_a`/`opr_b`/`alu_func` that drive the ALU combinationally. It is a single-entry pipeline register with stall and flush control.

## Interface

Parameters:
- `XLEN`, default 64: datapath width.

Ports:
- `clk_i` input, 1 bit: clock. All state changes on the rising edge.
- `rst_i` input, 1 bit: synchronous reset, active-high.
- `dec_valid_i` input, 1 bit: decode offers an instruction.
- `dec_ready_o` output, 1 bit: the stage accepts the offered instruction this cycle.
- `dec_pc_i` input, XLEN bits: instruction PC.
- `dec_imm_i` input, XLEN bits: immediate, already sign-extended.
- `dec_rs1_addr_i`, `dec_rs2_addr_i`, `dec_rd_addr_i` input, 5 bits each: register addresses.
- `dec_rd_wen_i`, `dec_is_load_i`, `dec_is_store_i` input, 1 bit each: instruction class flags.
- `dec_opa_sel_i` input, 2 bits: operand A source. 0 = rs1, 1 = PC, 2/3 = zero.
- `dec_opb_sel_i` input, 1 bit: operand B source. 0 = rs2, 1 = immediate.
- `dec_alu_func_i` input, 4 bits: ALU opcode (`cpu_consts` OP_* encoding).
- `rf_rs1_data_i`, `rf_rs2_data_i` input, XLEN bits: register file read data. Combinational; reads x0 as 0; reflects writes committed by earlier edges only.
- `alu_res_i` input, XLEN bits: execute result of the instruction currently held here.
- `exm_valid_i`, `exm_rd_wen_i`, `exm_is_load_i` input, 1 bit each: EX/MEM register status.
- `exm_rd_addr_i` input, 5 bits: EX/MEM destination register.
- `exm_rd_data_i` input, XLEN bits: EX/MEM result. Meaningless when `exm_is_load_i` is set.
- `wb_valid_i`, `wb_rd_wen_i` input, 1 bit each: writeback status.
- `wb_rd_addr_i` input, 5 bits: writeback destination register.
- `wb_rd_data_i` input, XLEN bits: writeback data.
- `flush_i` input, 1 bit: kill the held instruction and the offered instruction.
- `ex_valid_o` output, 1 bit: the held instruction is valid.
- `ex_ready_i` input, 1 bit: downstream consumes the held instruction this cycle.
- `opr_a_o`, `opr_b_o` output, XLEN bits: ALU operands.
- `alu_func_o` output, 4 bits: ALU opcode.
- `ex_rs2_data_o` output, XLEN bits: forwarded rs2 value, used as store data.
- `ex_pc_o` output, XLEN bits: PC of the held instruction.
- `ex_rd_addr_o` output, 5 bits: destination register of the held instruction.
- `ex_rd_wen_o`, `ex_is_load_o`, `ex_is_store_o` output, 1 bit each: flags of the held instruction.

## Operation

- **Usage.** rs1 is used when `dec_opa_sel_i == 0`. rs2 is used when `dec_opb_sel_i == 0` or `dec_is_store_i` is set. Address 0 is never a hazard and is never forwarded.
- **Fire.** `ex_fire = ex_valid_o & ex_ready_i`.
- **Forwarding.** Per used source, first match wins:
  1. Held instruction: `ex_fire & ex_rd_wen_o & !ex_is_load_o & ex_rd_addr_o == rs` gives `alu_res_i`.
  2. EX/MEM: `exm_valid_i & exm_rd_wen_i & !exm_is_load_i` and address match gives `exm_rd_data_i`.
  3. Writeback: `wb_valid_i & wb_rd_wen_i` and address match gives `wb_rd_data_i`.
  4. Otherwise the register file value.
- **Load-use stall.** A used source matching either of these stalls the stage:
  - a held load: `ex_valid_o & ex_is_load_o & ex_rd_wen_o`;
  - an EX/MEM load: `exm_valid_i & exm_is_load_i & exm_rd_wen_i`.
- **Ready.** `dec_ready_o = (!ex_valid_o | ex_ready_i) & !stall & !flush_i`. It depends combinationally on `ex_ready_i` and the hazard inputs.
- **Capture.** On `dec_valid_i & dec_ready_o`, all `ex_*` outputs, `opr_a_o`, `opr_b_o` and `alu_func_o` load the selected values, and `ex_valid_o` becomes 1.
  - `opr_a_o` is forwarded rs1, `dec_pc_i`, or 0, per `dec_opa_sel_i`.
  - `opr_b_o` is forwarded rs2 or `dec_imm_i`, per `dec_opb_sel_i`.
- **Drain.** If `ex_fire` occurs with no capture, `ex_valid_o` becomes 0 next edge.
- **Hold.** If `ex_valid_o & !ex_ready_i`, all outputs hold their values.
- **Flush.** `flush_i` has priority over capture and hold. Next edge: `ex_valid_o = 0`, and the offered instruction is not accepted.
- **Reset.** Priority: reset, then flush, then capture, then hold. Reset clears every registered output to 0, including `ex_valid_o = 0`.

## Timing

- Latency: 1 cycle from an accepted decode handshake to `ex_valid_o = 1` with final operands.
- Throughput: 1 instruction/cycle with no hazards and `ex_ready_i` held high.
- Load-use penalty:
  - a load held here stalls a dependent instruction for at least 1 cycle;
  - a load in EX/MEM stalls it for 1 further cycle, until the load is in writeback and forwarded.
- Registered outputs change only on `clk_i` edges. `dec_ready_o` is combinational.
- Reset mid-operation discards the held instruction. `dec_ready_o = 1` in the first cycle after reset if `flush_i = 0`.

## Test plan

- **Back-to-back ALU.** Send `ADD x1 = 5 + 7`, then `ADD x2 = x1 + 1` with the RF still holding x1 = 0. Expect `opr_a_o = 12` via held-result forwarding and no stall.
- **Load-use.** Send `LD x3`, then `ADD x4 = x3 + x0`. Expect `dec_ready_o = 0` for 2 cycles. With `wb_rd_data_i = 0x55` for x3, the ADD captures `opr_a_o = 0x55`.
- **Priority.** EX/MEM offers x5 = 9 and writeback offers x5 = 3 in the same cycle. Expect `opr_b_o = 9`. A source of x0 gives `opr_a_o = 0` despite a writeback to x0 of 0xFF.
- **Backpressure.** Hold `ex_ready_i = 0` for 3 cycles. Expect outputs stable and `dec_ready_o = 0`. On release, the next instruction captures the same cycle.
- **Flush and reset.** Assert `flush_i` with `dec_valid_i = 1`. Next cycle `ex_valid_o = 0` and nothing is accepted. Assert `rst_i` mid-stream. Next cycle all outputs are 0.
- **Operand select.** `opa_sel = 1` with PC 0x1000 and `opb_sel = 1` with imm -4 gives `opr_a_o = 0x1000` and `opr_b_o = 0xFFFF_FFFF_FFFF_FFFC`.
